// File: rtl/cla_clked.sv
// ---------------------------------------------------------------------------
// cla_clked
//
// Registered 4-bit carry-lookahead adder. Operands and carry-in are captured
// into an input register. A flat single-level lookahead adder works on that
// register, and the result is captured into an output register. The latency
// is two rising edges and the block accepts one operation per cycle.
//
// Ports
//   CLK   in   1  clock, rising-edge active
//   RST   in   1  asynchronous active-high reset, clears every register
//   a     in   4  operand A, unsigned
//   b     in   4  operand B, unsigned
//   Cin   in   1  carry-in
//   sum   out  4  registered sum bits [3:0] of a + b + Cin
//   Cout  out  1  registered carry-out (bit 4 of a + b + Cin)
// ---------------------------------------------------------------------------
module cla_clked (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       Cin,
    output logic [3:0] sum,
    output logic       Cout
);

    // Stage-1 operand registers
    logic [3:0] a_q_r;
    logic [3:0] b_q_r;
    logic       cin_q_r;

    // Lookahead terms and results, computed from stage-1 registers only
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;
    logic [3:0] sum_s;

    // Stage-2 result registers
    logic [3:0] sum_r;
    logic       cout_r;

    // Stage 1: capture operands and carry-in
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q_r   <= 4'b0000;
            b_q_r   <= 4'b0000;
            cin_q_r <= 1'b0;
        end else begin
            a_q_r   <= a;
            b_q_r   <= b;
            cin_q_r <= Cin;
        end
    end

    // Generate/propagate terms plus flat sum-of-products carries.
    // Each carry is expanded fully in g, p and c0, so no carry is
    // derived from a lower computed carry and no ripple path exists.
    always_comb begin
        g_s   = 4'b0000;
        p_s   = 4'b0000;
        c_s   = 5'b00000;
        sum_s = 4'b0000;

        g_s = a_q_r & b_q_r;
        p_s = a_q_r ^ b_q_r;

        c_s[0] = cin_q_r;
        c_s[1] = g_s[0]
               | (p_s[0] & cin_q_r);
        c_s[2] = g_s[1]
               | (p_s[1] & g_s[0])
               | (p_s[1] & p_s[0] & cin_q_r);
        c_s[3] = g_s[2]
               | (p_s[2] & g_s[1])
               | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin_q_r);
        c_s[4] = g_s[3]
               | (p_s[3] & g_s[2])
               | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin_q_r);

        sum_s = p_s ^ c_s[3:0];
    end

    // Stage 2: capture sum and carry-out so outputs come only from flops
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sum_r  <= 4'b0000;
            cout_r <= 1'b0;
        end else begin
            sum_r  <= sum_s;
            cout_r <= c_s[4];
        end
    end

    assign sum  = sum_r;
    assign Cout = cout_r;

endmodule

// File: tb/tb_cla_clked.sv
// ---------------------------------------------------------------------------
// tb_cla_clked
//
// Self-checking bench for cla_clked. Inputs are driven on the falling edge.
// The expected {Cout, sum} for each operand set is pushed to a queue when
// that set is driven. The entry is popped and compared two falling edges
// later, after the two rising edges of pipeline latency.
// ---------------------------------------------------------------------------
module tb_cla_clked;

    logic       CLK;
    logic       RST;
    logic [3:0] a;
    logic [3:0] b;
    logic       Cin;
    logic [3:0] sum;
    logic       Cout;

    int n_vec;
    int n_err;

    logic [4:0] exp_q[$];

    cla_clked dut (
        .CLK  (CLK),
        .RST  (RST),
        .a    (a),
        .b    (b),
        .Cin  (Cin),
        .sum  (sum),
        .Cout (Cout)
    );

    // Free-running clock, period 10
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got {Cout,sum}=%b_%b expected %b_%b",
                     tag, obs[4], obs[3:0], exp[4], exp[3:0]);
        end
    endtask

    // Independent model of the expected adder result
    function automatic logic [4:0] model(input logic [3:0] x, input logic [3:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {4'b0000, c};
    endfunction

    // One cycle: on the falling edge, check the result now due, then
    // drive new operands and push their expectation
    task automatic apply(input string tag, input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] e;
        @(negedge CLK);
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check(tag, {Cout, sum}, e);
        end else begin
            // Pipeline still filling after reset: cleared registers give zero
            check("fill", {Cout, sum}, 5'd0);
        end
        a   = x;
        b   = y;
        Cin = c;
        exp_q.push_back(model(x, y, c));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RST = 1'b1;
        a   = 4'd0;
        b   = 4'd0;
        Cin = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("reset", {Cout, sum}, 5'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Directed adds
        apply("dir_3_2_1",   4'd3,  4'd2,  1'b1);
        apply("dir_15_15_1", 4'd15, 4'd15, 1'b1);
        apply("dir_5_5_0",   4'd5,  4'd5,  1'b0);
        apply("dir_15_1_1",  4'd15, 4'd1,  1'b1);
        // Full propagate chain
        apply("prop_c1", 4'b1010, 4'b0101, 1'b1);
        apply("prop_c0", 4'b1010, 4'b0101, 1'b0);

        // Back-to-back distinct operands
        for (int i = 0; i < 8; i++) begin
            apply("b2b", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'(i & 1));
        end

        // Hold: constant inputs for several cycles
        for (int i = 0; i < 5; i++) begin
            apply("hold", 4'd9, 4'd12, 1'b1);
        end
        // Hold: outputs are also stable in mid-high phase
        @(posedge CLK);
        #2;
        check("hold_hi", {Cout, sum}, model(4'd9, 4'd12, 1'b1));

        // Mid-stream async reset with nonzero operands in flight
        apply("pre_rst", 4'd7, 4'd8, 1'b1);
        apply("pre_rst", 4'd6, 4'd6, 1'b1);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("rst_async", {Cout, sum}, 5'd0);
        @(posedge CLK);
        #1;
        check("rst_hold", {Cout, sum}, 5'd0);
        exp_q.delete();
        // Release with zero inputs; stale stage-1 data would show up as fill errors
        @(negedge CLK);
        RST = 1'b0;
        a   = 4'd0;
        b   = 4'd0;
        Cin = 1'b0;

        // Exhaustive sweep
        for (int c = 0; c < 2; c++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    apply("sweep", 4'(x), 4'(y), 1'(c));
                end
            end
        end

        // Drain the pipeline
        apply("drain", 4'd0, 4'd0, 1'b0);
        apply("drain", 4'd0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
